// File: rtl/branch_recovery.sv
// Misprediction recovery for the static conditional-branch predictor: shadows decoded
// branches until resolution, issues predicted/corrective redirects, flush and statistics.
module branch_recovery #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dec_valid,
  input  logic              dec_is_cond,
  input  logic [ADDR_W-1:0] dec_pc,
  input  logic [ADDR_W-1:0] dec_offset,
  input  logic              predict_branch,
  input  logic              is_branch,
  input  logic              n_is_branch,
  input  logic              clr_cnt,
  output logic              pred_redirect,
  output logic [ADDR_W-1:0] pred_pc,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              proto_err,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  localparam int unsigned FC_W = 4;

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  state_t              r_state;
  logic [FC_W-1:0]     r_fcnt;
  logic                r_flush;

  logic                r_s1_valid, r_s1_cond;
  logic [ADDR_W-1:0]   r_s1_target, r_s1_ft;
  logic                r_s2_valid, r_s2_cond;
  logic [ADDR_W-1:0]   r_s2_target, r_s2_ft;

  logic                r_pred_redirect, r_redirect, r_proto_err;
  logic [ADDR_W-1:0]   r_pred_pc, r_redirect_pc;
  logic [CNT_W-1:0]    r_branch_cnt, r_mispredict_cnt;

  logic                w_flushing, w_resolve, w_mis, w_pred;
  logic [ADDR_W-1:0]   w_target, w_ft;

  assign w_flushing = (r_state == ST_FLUSH);
  assign w_target   = dec_pc + dec_offset;
  assign w_ft       = dec_pc + ADDR_W'(1);
  assign w_resolve  = r_s2_valid & r_s2_cond & ~w_flushing;
  assign w_mis      = w_resolve & (is_branch | n_is_branch);
  // A corrective redirect in the same cycle overrides the predicted one.
  assign w_pred     = dec_valid & dec_is_cond & predict_branch & ~w_flushing & ~w_mis;

  // Flush sequencer: holds flush for FLUSH_CYC cycles after a corrective redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_fcnt  <= '0;
      r_flush <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mis) begin
            r_state <= ST_FLUSH;
            r_fcnt  <= FC_W'(FLUSH_CYC);
            r_flush <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (r_fcnt <= FC_W'(1)) begin
            r_state <= ST_IDLE;
            r_fcnt  <= '0;
            r_flush <= 1'b0;
          end else begin
            r_fcnt  <= r_fcnt - FC_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_fcnt  <= '0;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  // Shadow pipeline, redirect outputs, sticky protocol error and statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid       <= 1'b0;
      r_s1_cond        <= 1'b0;
      r_s1_target      <= '0;
      r_s1_ft          <= '0;
      r_s2_valid       <= 1'b0;
      r_s2_cond        <= 1'b0;
      r_s2_target      <= '0;
      r_s2_ft          <= '0;
      r_pred_redirect  <= 1'b0;
      r_pred_pc        <= '0;
      r_redirect       <= 1'b0;
      r_redirect_pc    <= '0;
      r_proto_err      <= 1'b0;
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      r_s1_valid  <= dec_valid & ~w_flushing & ~w_mis;
      r_s1_cond   <= dec_is_cond;
      r_s1_target <= w_target;
      r_s1_ft     <= w_ft;
      r_s2_valid  <= r_s1_valid & ~w_mis;
      r_s2_cond   <= r_s1_cond;
      r_s2_target <= r_s1_target;
      r_s2_ft     <= r_s1_ft;

      r_redirect <= w_mis;
      if (w_mis) r_redirect_pc <= is_branch ? r_s2_target : r_s2_ft;

      r_pred_redirect <= w_pred;
      if (w_pred) r_pred_pc <= w_target;

      if (w_resolve & is_branch & n_is_branch) r_proto_err <= 1'b1;

      if (clr_cnt)                            r_branch_cnt <= '0;
      else if (w_resolve && r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + CNT_W'(1);

      if (clr_cnt)                                r_mispredict_cnt <= '0;
      else if (w_mis && r_mispredict_cnt != '1) r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
    end
  end

  assign pred_redirect  = r_pred_redirect;
  assign pred_pc        = r_pred_pc;
  assign redirect       = r_redirect;
  assign redirect_pc    = r_redirect_pc;
  assign flush          = r_flush;
  assign proto_err      = r_proto_err;
  assign branch_cnt     = r_branch_cnt;
  assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_recovery.sv
// Bench for branch_recovery: directed scenarios plus randomized traffic against a
// lifetime-based reference model (a branch survives unless a redirect fires while it is in flight).
module tb_branch_recovery;

  localparam int unsigned AW   = 16;
  localparam int unsigned FC   = 2;
  localparam int unsigned CW   = 4;
  localparam int          MAXC = 8192;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          dec_valid, dec_is_cond, predict_branch, is_branch, n_is_branch, clr_cnt;
  logic [AW-1:0] dec_pc, dec_offset;
  logic          pred_redirect, redirect, flush, proto_err;
  logic [AW-1:0] pred_pc, redirect_pc;
  logic [CW-1:0] branch_cnt, mispredict_cnt;

  branch_recovery #(.ADDR_W(AW), .FLUSH_CYC(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .dec_valid(dec_valid), .dec_is_cond(dec_is_cond), .dec_pc(dec_pc), .dec_offset(dec_offset),
    .predict_branch(predict_branch), .is_branch(is_branch), .n_is_branch(n_is_branch),
    .clr_cnt(clr_cnt),
    .pred_redirect(pred_redirect), .pred_pc(pred_pc), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush(flush), .proto_err(proto_err),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: per-decode-cycle history and expected outputs.
  bit            m_cap  [MAXC];
  bit            m_cond [MAXC];
  bit            m_mis  [MAXC];
  logic [AW-1:0] m_pc   [MAXC];
  logic [AW-1:0] m_off  [MAXC];
  int            cyc = 0;
  int            rst_c = 0;
  int            fl_rem = 0;
  bit            e_red, e_pred, e_flush, e_perr;
  logic [AW-1:0] e_rpc, e_ppc;
  int            e_bc, e_mc;

  task automatic model_reset();
    fl_rem = 0; e_red = 0; e_pred = 0; e_flush = 0; e_perr = 0;
    e_rpc = '0; e_ppc = '0; e_bc = 0; e_mc = 0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    dec_valid = 0; dec_is_cond = 0; dec_pc = '0; dec_offset = '0;
    predict_branch = 0; is_branch = 0; n_is_branch = 0; clr_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rst_c = cyc;
  endtask

  // Drive one cycle of inputs, advance the model, and return just after the sampling edge.
  task automatic step(input bit dv, input bit c, input logic [AW-1:0] pc, input logic [AW-1:0] off,
                      input bit pb, input bit ib, input bit nb, input bit cl);
    bit fl, q;
    int d;
    @(negedge clk);
    dec_valid = dv; dec_is_cond = c; dec_pc = pc; dec_offset = off;
    predict_branch = pb; is_branch = ib; n_is_branch = nb; clr_cnt = cl;
    fl = (fl_rem > 0);
    d  = cyc - 2;
    q  = (d >= rst_c) && m_cap[d] && m_cond[d] && !fl && !((cyc - 1 >= rst_c) && m_mis[cyc-1]);
    m_mis[cyc]  = q && (ib || nb);
    m_cap[cyc]  = dv && !fl && !m_mis[cyc];
    m_cond[cyc] = c;
    m_pc[cyc]   = pc;
    m_off[cyc]  = off;
    e_red = m_mis[cyc];
    if (m_mis[cyc]) e_rpc = ib ? AW'(m_pc[d] + m_off[d]) : AW'(m_pc[d] + 16'd1);
    e_pred = dv && c && pb && !fl && !m_mis[cyc];
    if (e_pred) e_ppc = AW'(pc + off);
    if (cl) e_bc = 0; else if (q && e_bc < CMAX) e_bc++;
    if (cl) e_mc = 0; else if (m_mis[cyc] && e_mc < CMAX) e_mc++;
    if (q && ib && nb) e_perr = 1;
    if (m_mis[cyc]) fl_rem = FC; else if (fl_rem > 0) fl_rem--;
    e_flush = (fl_rem > 0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({pred_redirect, redirect, flush, proto_err} !== 4'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 0000", {pred_redirect, redirect, flush, proto_err});
    end
    checks++;
    if ({branch_cnt, mispredict_cnt, pred_pc, redirect_pc} !== '0) begin
      failures++; $display("FAIL reset_values: got bc=%h mc=%h ppc=%h rpc=%h expected zeros",
                           branch_cnt, mispredict_cnt, pred_pc, redirect_pc);
    end
  endtask

  task automatic test_backward_bne();
    step(1, 1, 16'h0040, 16'hFFF0, 1, 0, 0, 0);
    checks++;
    if (pred_redirect !== 1'b1 || pred_pc !== 16'h0030) begin
      failures++; $display("FAIL bne_pred: got %b/%h expected 1/0030", pred_redirect, pred_pc);
    end
    step(0, 0, '0, '0, 0, 0, 0, 0);
    checks++;
    if (pred_redirect !== 1'b0 || pred_pc !== 16'h0030) begin
      failures++; $display("FAIL bne_pred_hold: got %b/%h expected 0/0030", pred_redirect, pred_pc);
    end
    step(0, 0, '0, '0, 0, 0, 1, 0);
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 16'h0041 || flush !== 1'b1) begin
      failures++; $display("FAIL bne_redirect: got %b/%h/%b expected 1/0041/1", redirect, redirect_pc, flush);
    end
    checks++;
    if (mispredict_cnt !== 4'd1 || branch_cnt !== 4'd1) begin
      failures++; $display("FAIL bne_counts: got mc=%0d bc=%0d expected 1/1", mispredict_cnt, branch_cnt);
    end
    idle(1);
    checks++;
    if (flush !== 1'b1 || redirect !== 1'b0 || redirect_pc !== 16'h0041) begin
      failures++; $display("FAIL bne_flush2: got %b/%b/%h expected 1/0/0041", flush, redirect, redirect_pc);
    end
    idle(1);
    checks++;
    if (flush !== 1'b0) begin
      failures++; $display("FAIL bne_flush_end: got %b expected 0", flush);
    end
  endtask

  task automatic test_forward_beq();
    step(1, 1, 16'h0100, 16'h0020, 0, 0, 0, 0);
    checks++;
    if (pred_redirect !== 1'b0) begin
      failures++; $display("FAIL beq_no_pred: got %b expected 0", pred_redirect);
    end
    step(0, 0, '0, '0, 0, 0, 0, 0);
    step(0, 0, '0, '0, 0, 1, 0, 0);
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 16'h0120) begin
      failures++; $display("FAIL beq_redirect: got %b/%h expected 1/0120", redirect, redirect_pc);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    step(0, 0, '0, '0, 0, 0, 0, 1);
    checks++;
    if (branch_cnt !== 4'd0 || mispredict_cnt !== 4'd0) begin
      failures++; $display("FAIL clr_cnt: got bc=%0d mc=%0d expected 0/0", branch_cnt, mispredict_cnt);
    end
    step(1, 1, 16'h0300, 16'h0008, 0, 0, 0, 0);
    step(1, 1, 16'h0310, 16'h0004, 0, 0, 0, 0);
    step(0, 0, '0, '0, 0, 0, 1, 0);
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 16'h0301) begin
      failures++; $display("FAIL b2b_first: got %b/%h expected 1/0301", redirect, redirect_pc);
    end
    step(0, 0, '0, '0, 0, 1, 0, 0);
    checks++;
    if (redirect !== 1'b0 || branch_cnt !== 4'd1 || mispredict_cnt !== 4'd1) begin
      failures++; $display("FAIL b2b_second_ignored: got red=%b bc=%0d mc=%0d expected 0/1/1",
                           redirect, branch_cnt, mispredict_cnt);
    end
    idle(3);
  endtask

  task automatic test_wrap_proto();
    checks++;
    if (proto_err !== 1'b0) begin
      failures++; $display("FAIL proto_pre: got %b expected 0", proto_err);
    end
    step(1, 1, 16'hFFFF, 16'h0005, 0, 0, 0, 0);
    step(0, 0, '0, '0, 0, 0, 0, 0);
    step(0, 0, '0, '0, 0, 1, 1, 0);
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 16'h0004 || proto_err !== 1'b1) begin
      failures++; $display("FAIL wrap_both: got %b/%h/%b expected 1/0004/1", redirect, redirect_pc, proto_err);
    end
    idle(2);
    step(1, 1, 16'hFFFF, 16'h0005, 0, 0, 0, 0);
    step(0, 0, '0, '0, 0, 0, 0, 0);
    step(0, 0, '0, '0, 0, 0, 1, 0);
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 16'h0000 || proto_err !== 1'b1) begin
      failures++; $display("FAIL wrap_fallthrough: got %b/%h/%b expected 1/0000/1", redirect, redirect_pc, proto_err);
    end
    idle(2);
  endtask

  task automatic test_random();
    bit ok;
    for (int i = 0; i < 400; i++) begin
      step($urandom % 4 != 0, $urandom % 2 == 0, 16'($urandom), 16'($urandom), $urandom % 2 == 0,
           $urandom % 5 == 0, $urandom % 5 == 0, $urandom % 50 == 0);
      checks++;
      ok = (redirect === e_red) && (flush === e_flush) && (pred_redirect === e_pred) && (proto_err === e_perr);
      if (!ok) begin
        failures++; $display("FAIL rand_flags cyc=%0d: got red=%b fl=%b pr=%b pe=%b expected %b %b %b %b",
                             cyc, redirect, flush, pred_redirect, proto_err, e_red, e_flush, e_pred, e_perr);
      end
      checks++;
      if (redirect_pc !== e_rpc || pred_pc !== e_ppc) begin
        failures++; $display("FAIL rand_pcs cyc=%0d: got rpc=%h ppc=%h expected %h %h",
                             cyc, redirect_pc, pred_pc, e_rpc, e_ppc);
      end
      checks++;
      if (branch_cnt !== CW'(e_bc) || mispredict_cnt !== CW'(e_mc)) begin
        failures++; $display("FAIL rand_cnts cyc=%0d: got bc=%0d mc=%0d expected %0d %0d",
                             cyc, branch_cnt, mispredict_cnt, e_bc, e_mc);
      end
    end
    idle(4);
  endtask

  task automatic test_saturation();
    step(0, 0, '0, '0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 16'(16'h0500 + i), 16'h0010, 0, 0, 0, 0);
      step(0, 0, '0, '0, 0, 0, 0, 0);
      step(0, 0, '0, '0, 0, 0, 1, 0);
      idle(2);
    end
    checks++;
    if (mispredict_cnt !== 4'hF || branch_cnt !== 4'hF) begin
      failures++; $display("FAIL saturate: got mc=%h bc=%h expected F/F", mispredict_cnt, branch_cnt);
    end
    step(1, 1, 16'h0600, 16'h0010, 0, 0, 0, 0);
    step(0, 0, '0, '0, 0, 0, 0, 0);
    step(0, 0, '0, '0, 0, 0, 1, 1);
    checks++;
    if (redirect !== 1'b1 || mispredict_cnt !== 4'h0 || branch_cnt !== 4'h0) begin
      failures++; $display("FAIL clr_wins: got red=%b mc=%h bc=%h expected 1/0/0", redirect, mispredict_cnt, branch_cnt);
    end
    idle(2);
  endtask

  task automatic test_reset_mid_flush();
    step(1, 1, 16'h0700, 16'h0040, 0, 0, 0, 0);
    step(0, 0, '0, '0, 0, 0, 0, 0);
    step(0, 0, '0, '0, 0, 0, 1, 0);
    idle(1);
    checks++;
    if (flush !== 1'b1 || mispredict_cnt === 4'h0) begin
      failures++; $display("FAIL preflush: got fl=%b mc=%h expected 1/nonzero", flush, mispredict_cnt);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (flush !== 1'b0 || redirect !== 1'b0 || mispredict_cnt !== 4'h0 || branch_cnt !== 4'h0) begin
      failures++; $display("FAIL async_reset: got fl=%b red=%b mc=%h bc=%h expected 0/0/0/0",
                           flush, redirect, mispredict_cnt, branch_cnt);
    end
    apply_reset();
    step(1, 1, 16'h0200, 16'h0010, 1, 0, 0, 0);
    checks++;
    if (pred_redirect !== 1'b1 || pred_pc !== 16'h0210) begin
      failures++; $display("FAIL post_reset_pred: got %b/%h expected 1/0210", pred_redirect, pred_pc);
    end
    step(0, 0, '0, '0, 0, 0, 0, 0);
    step(0, 0, '0, '0, 0, 1, 0, 0);
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 16'h0210 || branch_cnt !== 4'd1) begin
      failures++; $display("FAIL post_reset_capture: got %b/%h bc=%0d expected 1/0210/1",
                           redirect, redirect_pc, branch_cnt);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_backward_bne();
    test_forward_beq();
    test_back_to_back();
    test_wrap_proto();
    test_random();
    test_saturation();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
